// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution PE output path.
package conv_pkg;

    localparam int P_WIDTH = 48;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        return result;
    endfunction

    // Largest value representable in a signed field of the given width.
    function automatic logic signed [P_WIDTH-1:0] sat_max(input int width);
        logic signed [P_WIDTH-1:0] one;
        one = P_WIDTH'(1);
        return (one <<< (width - 1)) - one;
    endfunction

    function automatic logic signed [P_WIDTH-1:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-wrap-bit pointers and a synchronous flush.
module sync_fifo
    import conv_pkg::*;
#(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/conv_out_collector.sv
// Filters the PE cascade stream to valid window positions, requantizes the
// kept results and queues them for write-back.
module conv_out_collector
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 3,
    parameter int SHIFT       = 0,
    parameter int OUT_WIDTH   = 16,
    parameter int RELU_EN     = 1,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic signed [P_WIDTH-1:0]   i_P,
    input  logic                        i_clear,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic signed [OUT_WIDTH-1:0] o_data,
    output logic                        o_last,
    output logic                        o_frame_done,
    output logic                        o_overflow
);

    localparam int CNT_W = (FM_SIZE > 1) ? clog2(FM_SIZE) : 1;
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(FM_SIZE - 1);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(KERNEL_SIZE - 1);
    localparam logic signed [P_WIDTH-1:0] Q_MAX = sat_max(OUT_WIDTH);
    localparam logic signed [P_WIDTH-1:0] Q_MIN = sat_min(OUT_WIDTH);

    logic [CNT_W-1:0]            col;
    logic [CNT_W-1:0]            row;
    logic                        accept;
    logic                        col_wrap;
    logic                        row_wrap;
    logic                        keep;
    logic                        last_pos;
    logic                        frame_wrap;
    logic signed [P_WIDTH-1:0]   q_shift;
    logic signed [P_WIDTH-1:0]   q_relu;
    logic signed [OUT_WIDTH-1:0] q_sat;

    logic                        stage_keep;
    logic signed [OUT_WIDTH-1:0] stage_data;
    logic                        stage_last;
    logic                        stage_done;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [OUT_WIDTH:0]          fifo_rdata;

    // A clear cycle swallows any sample presented alongside it.
    assign accept     = i_en && !i_clear;
    assign col_wrap   = (col == N_LAST);
    assign row_wrap   = (row == N_LAST);
    assign keep       = accept && (col >= K_LAST) && (row >= K_LAST);
    assign last_pos   = col_wrap && row_wrap;
    assign frame_wrap = accept && last_pos;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (i_clear) begin
            col <= '0;
            row <= '0;
        end else if (i_en) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_comb begin
        q_shift = i_P >>> SHIFT;
        q_relu  = q_shift;
        if ((RELU_EN != 0) && (q_shift < 0)) q_relu = '0;
        if (q_relu > Q_MAX)      q_sat = Q_MAX[OUT_WIDTH-1:0];
        else if (q_relu < Q_MIN) q_sat = Q_MIN[OUT_WIDTH-1:0];
        else                     q_sat = q_relu[OUT_WIDTH-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_keep <= 1'b0;
            stage_data <= '0;
            stage_last <= 1'b0;
            stage_done <= 1'b0;
        end else if (i_clear) begin
            stage_keep <= 1'b0;
            stage_done <= 1'b0;
        end else begin
            stage_keep <= keep;
            stage_done <= frame_wrap;
            if (keep) begin
                stage_data <= q_sat;
                stage_last <= last_pos;
            end
        end
    end

    // Handshake: the head is offered while o_valid=1 and is consumed on any
    // cycle with o_valid && i_ready; the head never changes before that pop.
    assign fifo_pop  = o_valid && i_ready;
    assign fifo_push = stage_keep && !i_clear;

    sync_fifo #(
        .WIDTH (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clear (i_clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({stage_data, stage_last}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow   <= 1'b0;
            o_frame_done <= 1'b0;
        end else if (i_clear) begin
            o_overflow   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= stage_done;
            if (stage_keep && fifo_full && !fifo_pop) o_overflow <= 1'b1;
        end
    end

    // Empty FIFO presents zeros rather than stale storage.
    assign o_valid = !fifo_empty;
    assign o_data  = fifo_empty ? '0 : fifo_rdata[OUT_WIDTH:1];
    assign o_last  = fifo_empty ? 1'b0 : fifo_rdata[0];

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench: six collector instances with different geometry and
// requantization settings, driven one at a time from a single sequence.
module tb_conv_out_collector;

    localparam int NUM = 6;
    localparam int CFG_K [NUM] = '{3, 3, 3, 1, 1, 1};
    localparam int CFG_N [NUM] = '{3, 4, 4, 2, 2, 2};
    localparam int CFG_D [NUM] = '{8, 8, 2, 8, 8, 8};
    localparam int CFG_S [NUM] = '{0, 0, 0, 0, 0, 4};
    localparam int CFG_R [NUM] = '{1, 1, 1, 1, 0, 0};

    logic               clk;
    logic               rst_n;
    logic               en  [NUM];
    logic signed [47:0] pd  [NUM];
    logic               clr [NUM];
    logic               rdy [NUM];
    logic               vld [NUM];
    logic signed [15:0] dat [NUM];
    logic               lst [NUM];
    logic               fdn [NUM];
    logic               ovf [NUM];

    int n_checks;
    int n_fail;

    for (genvar g = 0; g < NUM; g++) begin : g_dut
        conv_out_collector #(
            .KERNEL_SIZE (CFG_K[g]),
            .FM_SIZE     (CFG_N[g]),
            .SHIFT       (CFG_S[g]),
            .OUT_WIDTH   (16),
            .RELU_EN     (CFG_R[g]),
            .FIFO_DEPTH  (CFG_D[g])
        ) u_dut (
            .i_clk        (clk),
            .i_rst_n      (rst_n),
            .i_en         (en[g]),
            .i_P          (pd[g]),
            .i_clear      (clr[g]),
            .o_valid      (vld[g]),
            .i_ready      (rdy[g]),
            .o_data       (dat[g]),
            .o_last       (lst[g]),
            .o_frame_done (fdn[g]),
            .o_overflow   (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic stream(input int g, input int n);
        for (int i = 1; i <= n; i++) begin
            en[g] = 1'b1;
            pd[g] = 48'(i);
            tick();
        end
        en[g] = 1'b0;
    endtask

    task automatic send_one(input int g, input logic signed [47:0] v,
                            input logic signed [63:0] exp, input string tag);
        rdy[g] = 1'b1;
        en[g]  = 1'b1;
        pd[g]  = v;
        tick();
        en[g]  = 1'b0;
        tick();
        chk({tag, "_vld"}, vld[g], 1);
        chk({tag, "_dat"}, dat[g], exp);
        tick();
        chk({tag, "_popped"}, vld[g], 0);
    endtask

    // 4x4 frame through a 3x3 window: outputs 11,12,15,16, last on 16.
    task automatic run_edge_frame(input int g, input string tag);
        logic signed [15:0] exp_q [$];
        logic               exp_l [$];
        rdy[g] = 1'b0;
        chk({tag, "_start_empty"}, vld[g], 0);
        for (int i = 1; i <= 16; i++) begin
            en[g] = 1'b1;
            pd[g] = 48'(i);
            tick();
            if (i == 11) chk({tag, "_vld_before_latency"}, vld[g], 0);
            if (i == 12) begin
                chk({tag, "_vld_after_latency"}, vld[g], 1);
                chk({tag, "_first_head"}, dat[g], 11);
            end
        end
        en[g] = 1'b0;
        tick();
        chk({tag, "_frame_done"}, fdn[g], 1);
        tick();
        chk({tag, "_frame_done_pulse"}, fdn[g], 0);
        exp_q = '{16'sd11, 16'sd12, 16'sd15, 16'sd16};
        exp_l = '{1'b0, 1'b0, 1'b0, 1'b1};
        rdy[g] = 1'b1;
        while (exp_q.size() > 0) begin
            chk({tag, "_drain_vld"}, vld[g], 1);
            chk({tag, "_drain_dat"}, dat[g], exp_q.pop_front());
            chk({tag, "_drain_last"}, lst[g], exp_l.pop_front());
            tick();
        end
        rdy[g] = 1'b0;
        chk({tag, "_drained"}, vld[g], 0);
        chk({tag, "_no_overflow"}, ovf[g], 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int g = 0; g < NUM; g++) begin
            en[g]  = 1'b0;
            pd[g]  = '0;
            clr[g] = 1'b0;
            rdy[g] = 1'b0;
        end

        // Reset state of every instance
        #12;
        for (int g = 0; g < NUM; g++) begin
            chk("reset_valid", vld[g], 0);
            chk("reset_data", dat[g], 0);
            chk("reset_last", lst[g], 0);
            chk("reset_frame_done", fdn[g], 0);
            chk("reset_overflow", ovf[g], 0);
        end
        rst_n = 1'b1;
        tick();

        // Full 3x3 frame: only sample 9 survives
        rdy[0] = 1'b1;
        stream(0, 9);
        chk("f3_vld_latency", vld[0], 0);
        tick();
        chk("f3_vld", vld[0], 1);
        chk("f3_dat", dat[0], 9);
        chk("f3_last", lst[0], 1);
        chk("f3_frame_done", fdn[0], 1);
        tick();
        chk("f3_popped", vld[0], 0);
        chk("f3_frame_done_pulse", fdn[0], 0);

        // Edge-position filtering on a 4x4 frame
        run_edge_frame(1, "edge");

        // Saturation, ReLU and shift
        send_one(3, 48'sd70000, 32767, "sat_pos");
        send_one(3, -48'sd5, 0, "relu_neg");
        send_one(4, -48'sd70000, -32768, "sat_neg");
        send_one(4, 48'sd100, 100, "pass_pos");
        send_one(5, -48'sd33, -3, "shift_neg");
        send_one(5, 48'sd100, 6, "shift_pos");

        // Backpressure with a 2-entry FIFO
        rdy[2] = 1'b0;
        stream(2, 16);
        tick();
        tick();
        chk("bp_overflow", ovf[2], 1);
        chk("bp_vld", vld[2], 1);
        chk("bp_head0", dat[2], 11);
        rdy[2] = 1'b1;
        tick();
        chk("bp_head1", dat[2], 12);
        chk("bp_head1_last", lst[2], 0);
        tick();
        chk("bp_drained", vld[2], 0);
        chk("bp_overflow_sticky", ovf[2], 1);
        rdy[2] = 1'b0;

        // Clear, then push into a full FIFO while it pops
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        chk("clr_overflow", ovf[2], 0);
        chk("clr_vld", vld[2], 0);
        for (int i = 1; i <= 15; i++) begin
            en[2] = 1'b1;
            pd[2] = 48'(i);
            tick();
        end
        en[2]  = 1'b0;
        rdy[2] = 1'b1;
        tick();
        rdy[2] = 1'b0;
        chk("fullpop_overflow", ovf[2], 0);
        chk("fullpop_vld", vld[2], 1);
        chk("fullpop_head", dat[2], 12);
        rdy[2] = 1'b1;
        tick();
        chk("fullpop_new", dat[2], 15);
        chk("fullpop_new_last", lst[2], 0);
        tick();
        chk("fullpop_drained", vld[2], 0);
        rdy[2] = 1'b0;

        // Mid-frame clear with data buffered
        stream(1, 16);
        stream(1, 6);
        chk("mid_clr_pre_vld", vld[1], 1);
        clr[1] = 1'b1;
        en[1]  = 1'b1;
        pd[1]  = 48'sd99;
        tick();
        clr[1] = 1'b0;
        en[1]  = 1'b0;
        chk("mid_clr_vld", vld[1], 0);
        chk("mid_clr_frame_done", fdn[1], 0);
        tick();
        chk("mid_clr_frame_done_late", fdn[1], 0);
        run_edge_frame(1, "after_clear");

        // Asynchronous reset pulse mid-cycle, mid-frame
        stream(1, 16);
        stream(1, 6);
        chk("mid_rst_pre_vld", vld[1], 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", vld[1], 0);
        chk("mid_rst_data", dat[1], 0);
        chk("mid_rst_frame_done", fdn[1], 0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("mid_rst_frame_done_late", fdn[1], 0);
        run_edge_frame(1, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_out_collector.md
# conv_out_collector

Downstream stage of the DSP-cascade convolution PE. It consumes the PE's raw 48-bit accumulator stream and its `o_en` qualifier. It discards the cascade outputs that fall on invalid window positions: feature-map row wrap and the first K-1 rows. Kept results are requantized (arithmetic shift, optional ReLU, signed saturation) and buffered in a small FIFO behind a valid/ready handshake for the write-back path.

## Interface
Parameters:
- `KERNEL_SIZE`, 3: kernel side K; must match the PE.
- `FM_SIZE`, 3: feature-map side N, with N ≥ K; must match the PE.
- `SHIFT`, 0: arithmetic right shift applied to P, range 0..47.
- `OUT_WIDTH`, 16: signed output width, range 2..47.
- `RELU_EN`, 1: when 1, negative results become 0.
- `FIFO_DEPTH`, 8: output FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_en`  in  1  PE result valid (PE `o_en`).
- `i_P`  in  48  signed PE result (PE `o_P`).
- `i_clear`  in  1  synchronous frame restart.
- `o_valid`  out  1  FIFO head is valid.
- `i_ready`  in  1  consumer accepts the head.
- `o_data`  out  OUT_WIDTH  signed requantized result.
- `o_last`  out  1  head is the final output of its frame.
- `o_frame_done`  out  1  one-cycle pulse when the input frame completes.
- `o_overflow`  out  1  sticky: a kept result was dropped.

## Operation
- `col` and `row` counters, each 0..N-1, advance on every cycle where `i_en`=1.
  - `col` advances first; on wrap, `row` increments.
  - When both wrap, `o_frame_done` pulses and counting restarts at (0,0).
- A sample is kept iff `col` ≥ K-1 and `row` ≥ K-1. This gives (N-K+1)² outputs per frame.
- `last` is asserted on the sample at (N-1, N-1).
- Requantization, in order:
  1. q = i_P >>> SHIFT (sign-extending).
  2. If RELU_EN and q < 0, then q = 0.
  3. Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Stage register: holds {q, last}, a keep flag, and a frame-done flag.
- FIFO write occurs when the stage keep flag is 1 and either the FIFO is not full or a pop happens in the same cycle.
  - Otherwise the result is dropped and `o_overflow` is set.
  - `o_overflow` is cleared only by reset or `i_clear`.
- FIFO pop occurs when `o_valid` && `i_ready`. `o_data`/`o_last` show the FIFO head.
- `i_clear`=1 has the following effects:
  - Counters go to (0,0).
  - The stage register is invalidated.
  - The FIFO is emptied.
  - `o_overflow` is cleared.
  - `i_en` in the same cycle is ignored.
- Reset (`i_rst_n`=0, asynchronous) puts all outputs at 0: `o_valid`, `o_data`, `o_last`, `o_frame_done`, `o_overflow`. Counters and FIFO pointers are also 0.
- Reset or `i_clear` mid-frame abandons the partial frame. No `o_frame_done` is produced for it.

## Timing
- Sample accepted at clock edge n. Stage register is loaded at edge n. The FIFO write occurs at edge n+1. `o_valid` is high after edge n+1, so latency is 2 cycles into an empty FIFO.
- `o_frame_done` is high for exactly the cycle after edge n+1 for the sample at (N-1, N-1).
- Full throughput: with `i_ready` held at 1, one kept result is accepted per cycle and no overflow occurs.
- Simultaneous push and pop when full: both happen and the count is unchanged.
- Simultaneous push and pop when empty: the push is stored and `o_valid` rises next cycle. There is no bypass.
- The handshake holds the head stable; `o_data`/`o_last` change only after a pop.
- The PE has no backpressure. Drops are the defined behaviour when the FIFO is full.

## Structure
- Shared package `conv_pkg`:
  - `clog2` function.
  - PE result width constant (48).
  - Saturation min/max helper functions parameterized by width.
- Sub-module `sync_fifo`:
  - Parameterized by width (OUT_WIDTH+1) and depth.
  - Provides push/pop/full/empty and an async active-low reset.
- Counters, keep logic, requantization and the stage register live in `conv_out_collector`.

## Test plan
- **Full 3×3 frame:** N=3, K=3, i_P = 1..9 with `i_en`=1 continuously, `i_ready`=1. Exactly one output: `o_data`=9 with `o_last`=1. `o_frame_done` pulses 2 cycles after the 9th sample.
- **Edge-position filtering:** N=4, K=3, i_P = 1..16. Outputs are 11, 12, 15, 16 in order, with `o_last` only on 16. `o_valid` first rises 2 cycles after sample 11.
- **Saturation and ReLU:** OUT_WIDTH=16, SHIFT=0, RELU_EN=1. i_P=70000 gives 32767; i_P=-5 gives 0. With RELU_EN=0, i_P=-70000 gives -32768. With SHIFT=4, i_P=-33 gives -3.
- **Backpressure and overflow:** FIFO_DEPTH=2, N=4, K=3, `i_ready`=0. Values 11 and 12 are buffered, 15 and 16 are dropped, and `o_overflow`=1. Releasing `i_ready` then yields 11, 12 only.
- **Full FIFO with simultaneous pop:** With the FIFO full and `i_ready`=1 in the cycle a kept result arrives, the new value is stored and `o_overflow` stays 0.
- **Mid-frame restart:** Assert `i_clear` after sample 6 of a 4×4 frame, or pulse `i_rst_n` low asynchronously mid-cycle. The FIFO empties, no `o_frame_done` fires, and the next 16 samples behave as in the edge-filtering test.
